seq_pattern_detector: RTL

Parametrised serial pattern detector that compares a qualified bit stream against a programmable PAT_W-bit pattern. It supports overlapping and non-overlapping detection and an optional saturating match counter. It is the general replacement for the fixed 3-bit "101" Mealy detectors in the serial front-end, and drives one-cycle match pulses to downstream control logic.

---
 rtl/seq_pattern_detector_if.sv | 28 ++
 rtl/seq_pattern_detector.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/seq_pattern_detector_if.sv
// Serial pattern detector bus: qualified bit stream, pattern load and
// counter control in, match pulse and saturating match count out.
// The master modport belongs to the stream source, the slave modport
// to the detector.
interface seq_pattern_detector_if #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
);
    logic             d_valid;
    logic             d_in;
    logic             overlap;
    logic             load_pat;
    logic [PAT_W-1:0] pat_in;
    logic             clear;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             count_sat;

    modport master (
        output d_valid, d_in, overlap, load_pat, pat_in, clear,
        input  match, match_count, count_sat
    );

    modport slave (
        input  d_valid, d_in, overlap, load_pat, pat_in, clear,
        output match, match_count, count_sat
    );
endinterface

// File: rtl/seq_pattern_detector.sv
// Parametrised serial pattern detector.
// Compares the last PAT_W consumed bits (oldest bit against pattern[PAT_W-1])
// with a programmable pattern and emits a registered one-cycle match pulse.
// Overlapping or non-overlapping detection is selected per consumed bit.
// Optional saturating match counter is built only when SEQDET_COUNT_EN is
// defined; otherwise match_count/count_sat are tied to zero and clear is
// ignored. The port list is the same in both builds.
module seq_pattern_detector #(
    parameter int               PAT_W     = 3,
    parameter logic [PAT_W-1:0] PAT_RESET = 3'b101,
    parameter int               CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    seq_pattern_detector_if.slave bus
);

    // fill counts valid history bits, 0..PAT_W-1
    localparam int               FILL_W     = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_ARMED = FILL_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        PH_EMPTY,
        PH_FILLING,
        PH_ARMED
    } phase_e;

    logic [PAT_W-1:0]  pat_q,  pat_d;
    logic [PAT_W-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              match_q, match_d;

    phase_e            phase;
    logic              consume;
    logic [PAT_W-1:0]  window;
    logic              hit;

    // A bit is consumed only when qualified and not overridden by a pattern load
    assign consume = bus.d_valid & ~bus.load_pat;
    assign window  = {hist_q, bus.d_in};

    // Decode the fill phase from the history fill level
    always_comb begin
        if (fill_q == '0) begin
            phase = PH_EMPTY;
        end else if (fill_q == FILL_ARMED) begin
            phase = PH_ARMED;
        end else begin
            phase = PH_FILLING;
        end
    end

    // State register: pattern, history, fill level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_q  <= PAT_RESET;
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    // Next-state: load flushes history, consumed bits shift in and advance fill
    always_comb begin
        // NOTE: every comb output gets a hold default first, so no path leaves
        // a variable unassigned and no latch is inferred.
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (bus.load_pat) begin
            pat_d  = bus.pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (bus.d_valid) begin
            hist_d = window[PAT_W-2:0];
            unique case (phase)
                PH_EMPTY,
                PH_FILLING: fill_d = fill_q + 1'b1;
                PH_ARMED: begin
                    // Non-overlap restarts filling; the shift above still happens
                    if (hit && !bus.overlap) begin
                        fill_d = '0;
                    end
                end
                default: fill_d = '0;
            endcase
        end
    end

    // Output: compare a full window only when armed
    always_comb begin
        hit     = consume && (phase == PH_ARMED) && (window == pat_q);
        match_d = hit;
    end

    // Match pulse register; cleared whenever no hit occurs, so it never stretches
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    assign bus.match = match_q;

`ifdef SEQDET_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    // Counter next value: clear beats a coincident hit, count saturates at all-ones
    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (bus.clear) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (hit && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_MAX - 1'b1) begin
                sat_d = 1'b1;
            end
        end
    end

    // Counter and sticky saturation flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign bus.match_count = cnt_q;
    assign bus.count_sat   = sat_q;
`else
    assign bus.match_count = '0;
    assign bus.count_sat   = 1'b0;
`endif

endmodule
